// File: rtl/id_stage.sv
// ID stage of the five-stage MIPS pipeline: register file, decode, branch/jump
// resolution and the ID/EX pipeline register, including exception and delay-slot status.
module id_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [4:0]  ERR_NONE = 5'd31,
  parameter logic [4:0]  ERR_RI   = 5'd10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_D,
  input  logic [31:0] PC_4_D,
  input  logic [31:0] Instr_D,
  input  logic [4:0]  ErrStat_D,
  input  logic        Err_D,
  input  logic        Stall,
  input  logic        ErrSignal,
  input  logic        eretEn,
  input  logic        fwd_rs_en,
  input  logic [31:0] fwd_rs_data,
  input  logic        fwd_rt_en,
  input  logic [31:0] fwd_rt_data,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        branch,
  output logic        jump,
  output logic [31:0] branch_addr32,
  output logic [31:0] jump_addr32,
  output logic [31:0] PC_E,
  output logic [31:0] PC_4_E,
  output logic [31:0] Instr_E,
  output logic [31:0] RS_E,
  output logic [31:0] RT_E,
  output logic [31:0] Imm_E,
  output logic [4:0]  ErrStat_E,
  output logic        Err_E,
  output logic        BD_E
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs_a;
  logic [4:0]  rt_a;
  logic [15:0] imm16;
  logic [25:0] index;

  assign op    = Instr_D[31:26];
  assign rs_a  = Instr_D[25:21];
  assign rt_a  = Instr_D[20:16];
  assign imm16 = Instr_D[15:0];
  assign index = Instr_D[25:0];
  assign funct = Instr_D[5:0];

  // General register file; entry 0 is never written so it always reads zero.
  logic [31:0] grf [0:31];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        grf[i] <= '0;
      end
    end else if (wb_we && (wb_addr != 5'd0)) begin
      grf[wb_addr] <= wb_data;
    end
  end

  logic [31:0] rs_val;
  logic [31:0] rt_val;

  always_comb begin
    if (fwd_rs_en)
      rs_val = fwd_rs_data;
    else if (wb_we && (wb_addr == rs_a) && (rs_a != 5'd0))
      rs_val = wb_data;
    else if (rs_a == 5'd0)
      rs_val = '0;
    else
      rs_val = grf[rs_a];
  end

  always_comb begin
    if (fwd_rt_en)
      rt_val = fwd_rt_data;
    else if (wb_we && (wb_addr == rt_a) && (rt_a != 5'd0))
      rt_val = wb_data;
    else if (rt_a == 5'd0)
      rt_val = '0;
    else
      rt_val = grf[rt_a];
  end

  logic known;
  logic is_beq;
  logic is_bne;
  logic is_j;
  logic is_jal;
  logic is_jr;
  logic is_jalr;
  logic is_ori;
  logic is_lui;

  always_comb begin
    known   = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_j    = 1'b0;
    is_jal  = 1'b0;
    is_jr   = 1'b0;
    is_jalr = 1'b0;
    is_ori  = 1'b0;
    is_lui  = 1'b0;
    case (op)
      6'h00: begin
        case (funct)
          6'h21, 6'h23, 6'h24, 6'h25, 6'h2a, 6'h00: known = 1'b1;
          6'h08: begin known = 1'b1; is_jr   = 1'b1; end
          6'h09: begin known = 1'b1; is_jalr = 1'b1; end
          default: known = 1'b0;
        endcase
      end
      6'h0d: begin known = 1'b1; is_ori = 1'b1; end
      6'h0f: begin known = 1'b1; is_lui = 1'b1; end
      6'h09, 6'h23, 6'h2b: known = 1'b1;
      6'h04: begin known = 1'b1; is_beq = 1'b1; end
      6'h05: begin known = 1'b1; is_bne = 1'b1; end
      6'h02: begin known = 1'b1; is_j   = 1'b1; end
      6'h03: begin known = 1'b1; is_jal = 1'b1; end
      // COP0: mfc0 (rs=0), mtc0 (rs=4), eret (CO bit set, funct 0x18)
      6'h10: begin
        if (rs_a == 5'd0 || rs_a == 5'd4)
          known = 1'b1;
        else if (rs_a == 5'h10 && funct == 6'h18)
          known = 1'b1;
      end
      default: known = 1'b0;
    endcase
  end

  logic ri;
  logic exc_pending;
  logic redirect_block;
  logic is_jb;
  logic [31:0] imm_ext;

  assign ri             = ~known;
  assign exc_pending    = Err_D | ri;
  assign redirect_block = Stall | Err_D | ri;
  assign is_jb          = is_beq | is_bne | is_j | is_jal | is_jr | is_jalr;

  always_comb begin
    if (is_ori)
      imm_ext = {16'd0, imm16};
    else if (is_lui)
      imm_ext = {imm16, 16'd0};
    else
      imm_ext = {{16{imm16[15]}}, imm16};
  end

  assign branch_addr32 = PC_4_D + {{14{imm16[15]}}, imm16, 2'b00};
  assign jump_addr32   = (is_jr | is_jalr) ? rs_val : {PC_4_D[31:28], index, 2'b00};
  assign branch = ((is_beq & (rs_val == rt_val)) | (is_bne & (rs_val != rt_val))) & ~redirect_block;
  assign jump   = (is_j | is_jal | is_jr | is_jalr) & ~redirect_block;

  logic flush;
  logic prev_jb;

  assign flush = ErrSignal | eretEn;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      prev_jb <= 1'b0;
    else if (flush)
      prev_jb <= 1'b0;
    else if (!Stall)
      prev_jb <= is_jb & ~Err_D;
  end

  // A faulting instruction keeps its raw PC so the handler sees the bad address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || flush || Stall) begin
      PC_E      <= PC_RESET;
      PC_4_E    <= PC_RESET + 32'd4;
      Instr_E   <= '0;
      RS_E      <= '0;
      RT_E      <= '0;
      Imm_E     <= '0;
      ErrStat_E <= ERR_NONE;
      Err_E     <= 1'b0;
      BD_E      <= 1'b0;
    end else begin
      PC_E      <= exc_pending ? PC_D : {PC_D[31:2], 2'b00};
      PC_4_E    <= PC_4_D;
      Instr_E   <= exc_pending ? 32'd0 : Instr_D;
      RS_E      <= rs_val;
      RT_E      <= rt_val;
      Imm_E     <= imm_ext;
      ErrStat_E <= Err_D ? ErrStat_D : (ri ? ERR_RI : ERR_NONE);
      Err_E     <= exc_pending;
      BD_E      <= prev_jb;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: expectations are queued as stimulus is driven
// and checked with immediate assertions once the DUT output is due.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC_D, PC_4_D, Instr_D;
  logic [4:0]  ErrStat_D;
  logic        Err_D, Stall, ErrSignal, eretEn;
  logic        fwd_rs_en, fwd_rt_en;
  logic [31:0] fwd_rs_data, fwd_rt_data;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        branch, jump;
  logic [31:0] branch_addr32, jump_addr32;
  logic [31:0] PC_E, PC_4_E, Instr_E, RS_E, RT_E, Imm_E;
  logic [4:0]  ErrStat_E;
  logic        Err_E, BD_E;

  int checks = 0;
  int errors = 0;

  localparam int S_PC = 0, S_PC4 = 1, S_INSTR = 2, S_RS = 3, S_RT = 4, S_IMM = 5,
                 S_ESTAT = 6, S_ERR = 7, S_BD = 8, S_BR = 9, S_JMP = 10,
                 S_BADDR = 11, S_JADDR = 12;

  localparam logic [31:0] ADDU_1_5_0 = 32'h00A0_0821;
  localparam logic [31:0] J_3010     = 32'h0800_0C04;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  id_stage dut (
    .clk(clk), .reset(reset), .PC_D(PC_D), .PC_4_D(PC_4_D), .Instr_D(Instr_D),
    .ErrStat_D(ErrStat_D), .Err_D(Err_D), .Stall(Stall), .ErrSignal(ErrSignal),
    .eretEn(eretEn), .fwd_rs_en(fwd_rs_en), .fwd_rs_data(fwd_rs_data),
    .fwd_rt_en(fwd_rt_en), .fwd_rt_data(fwd_rt_data), .wb_we(wb_we),
    .wb_addr(wb_addr), .wb_data(wb_data), .branch(branch), .jump(jump),
    .branch_addr32(branch_addr32), .jump_addr32(jump_addr32), .PC_E(PC_E),
    .PC_4_E(PC_4_E), .Instr_E(Instr_E), .RS_E(RS_E), .RT_E(RT_E), .Imm_E(Imm_E),
    .ErrStat_E(ErrStat_E), .Err_E(Err_E), .BD_E(BD_E)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] observe(int sel);
    case (sel)
      S_PC:    return PC_E;
      S_PC4:   return PC_4_E;
      S_INSTR: return Instr_E;
      S_RS:    return RS_E;
      S_RT:    return RT_E;
      S_IMM:   return Imm_E;
      S_ESTAT: return {27'd0, ErrStat_E};
      S_ERR:   return {31'd0, Err_E};
      S_BD:    return {31'd0, BD_E};
      S_BR:    return {31'd0, branch};
      S_JMP:   return {31'd0, jump};
      S_BADDR: return branch_addr32;
      S_JADDR: return jump_addr32;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic push_bubble(input string tag);
    push({tag, "_pc"},    S_PC,    32'h0000_3000);
    push({tag, "_pc4"},   S_PC4,   32'h0000_3004);
    push({tag, "_instr"}, S_INSTR, 32'd0);
    push({tag, "_rs"},    S_RS,    32'd0);
    push({tag, "_rt"},    S_RT,    32'd0);
    push({tag, "_imm"},   S_IMM,   32'd0);
    push({tag, "_estat"}, S_ESTAT, 32'd31);
    push({tag, "_err"},   S_ERR,   32'd0);
    push({tag, "_bd"},    S_BD,    32'd0);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    reset = 1'b1;
    PC_D = 32'h3000; PC_4_D = 32'h3004; Instr_D = '0;
    ErrStat_D = 5'd31; Err_D = 1'b0; Stall = 1'b0; ErrSignal = 1'b0; eretEn = 1'b0;
    fwd_rs_en = 1'b0; fwd_rs_data = '0; fwd_rt_en = 1'b0; fwd_rt_data = '0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;

    #3;
    push_bubble("rst");
    drain();
    @(negedge clk);
    reset = 1'b0;

    // write $5, then read it through an unaligned-PC addu
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_AAAA;
    tick();
    wb_we = 1'b0;
    PC_D = 32'h3006; PC_4_D = 32'h300A; Instr_D = ADDU_1_5_0;
    push("ld_pc", S_PC, 32'h3004);
    push("ld_pc4", S_PC4, 32'h300A);
    push("ld_instr", S_INSTR, ADDU_1_5_0);
    push("ld_rs", S_RS, 32'h0000_AAAA);
    push("ld_rt", S_RT, 32'd0);
    push("ld_estat", S_ESTAT, 32'd31);
    push("ld_err", S_ERR, 32'd0);
    tick();

    // bne $5,$0 taken before reset; after async reset GRF $5 reads 0
    Instr_D = 32'h14A0_0001; PC_4_D = 32'h3010;
    push("bne5_br", S_BR, 32'd1);
    push("bne5_addr", S_BADDR, 32'h3014);
    tick();
    #2;
    reset = 1'b1;
    #1;
    push_bubble("midrst");
    push("midrst_grf5", S_BR, 32'd0);
    drain();
    reset = 1'b0;

    // WB bypass into the comparator
    wb_we = 1'b1; wb_addr = 5'd8; wb_data = 32'h1234;
    PC_4_D = 32'h3104; Instr_D = 32'h1100_0004;
    push("byp_beq", S_BR, 32'd0);
    #1; drain();
    Instr_D = 32'h1500_0004;
    push("byp_bne", S_BR, 32'd1);
    push("byp_baddr", S_BADDR, 32'h3114);
    #1; drain();
    wb_we = 1'b0;

    // forwarding wins for jr
    fwd_rs_en = 1'b1; fwd_rs_data = 32'h3010; Instr_D = 32'h03E0_0008;
    push("fwd_jump", S_JMP, 32'd1);
    push("fwd_jaddr", S_JADDR, 32'h3010);
    #1; drain();
    fwd_rs_en = 1'b0;

    // writes to $0 neither bypass nor land
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'd7;
    PC_D = 32'h3000; PC_4_D = 32'h3004; Instr_D = 32'h0000_0821;
    push("r0_byp", S_RS, 32'd0);
    tick();
    wb_we = 1'b0;
    push("r0_arr", S_RS, 32'd0);
    tick();

    // reserved instruction
    PC_D = 32'h3008; PC_4_D = 32'h300C; Instr_D = 32'hFC00_0000;
    push("ri_jump", S_JMP, 32'd0);
    push("ri_instr", S_INSTR, 32'd0);
    push("ri_err", S_ERR, 32'd1);
    push("ri_estat", S_ESTAT, 32'd10);
    push("ri_pc", S_PC, 32'h3008);
    tick();

    // AdEL from fetch keeps unaligned PC
    Err_D = 1'b1; ErrStat_D = 5'd4; PC_D = 32'h3001; PC_4_D = 32'h3005; Instr_D = 32'h0000_0000;
    push("adel_estat", S_ESTAT, 32'd4);
    push("adel_pc", S_PC, 32'h3001);
    push("adel_err", S_ERR, 32'd1);
    tick();
    Err_D = 1'b0; ErrStat_D = 5'd31;

    // immediate extension and decode coverage
    PC_D = 32'h3010; PC_4_D = 32'h3014;
    Instr_D = 32'h3401_8001; push("ori_imm", S_IMM, 32'h0000_8001); tick();
    Instr_D = 32'h3C01_8001; push("lui_imm", S_IMM, 32'h8001_0000); tick();
    Instr_D = 32'h2401_FFFF; push("addiu_imm", S_IMM, 32'hFFFF_FFFF); tick();
    Instr_D = 32'h8C01_0004; push("lw_err", S_ERR, 32'd0); push("lw_imm", S_IMM, 32'd4); tick();
    Instr_D = 32'h4200_0018; push("eret_err", S_ERR, 32'd0); push("eret_instr", S_INSTR, 32'h4200_0018); tick();
    Instr_D = 32'h4001_6000; push("mfc0_err", S_ERR, 32'd0); tick();

    // j sets prev_jb; stall bubbles and holds it
    PC_4_D = 32'h3020; Instr_D = J_3010;
    push("j_jump", S_JMP, 32'd1);
    push("j_jaddr", S_JADDR, 32'h3010);
    push("j_bd", S_BD, 32'd0);
    tick();
    Stall = 1'b1;
    push("stall_jump", S_JMP, 32'd0);
    push_bubble("stall");
    tick();
    Stall = 1'b0;
    Instr_D = ADDU_1_5_0;
    push("stall_held_bd", S_BD, 32'd1);
    tick();

    // stall together with flush clears prev_jb
    Instr_D = J_3010;
    push("j2_bd", S_BD, 32'd0);
    tick();
    Stall = 1'b1; ErrSignal = 1'b1; Instr_D = ADDU_1_5_0;
    push_bubble("flush");
    tick();
    Stall = 1'b0; ErrSignal = 1'b0;
    push("flush_bd", S_BD, 32'd0);
    tick();

    // eret flush also clears prev_jb
    Instr_D = J_3010;
    tick();
    eretEn = 1'b1; Instr_D = ADDU_1_5_0;
    push_bubble("eret");
    tick();
    eretEn = 1'b0;
    push("eret_bd", S_BD, 32'd0);
    tick();

    // delay slot after a not-taken beq
    fwd_rs_en = 1'b1; fwd_rs_data = 32'd5; PC_4_D = 32'h3040; Instr_D = 32'h1000_0004;
    push("ds_br", S_BR, 32'd0);
    push("ds_baddr", S_BADDR, 32'h3050);
    push("ds_beq_bd", S_BD, 32'd0);
    tick();
    fwd_rs_en = 1'b0;
    Instr_D = ADDU_1_5_0;
    push("ds_slot_bd", S_BD, 32'd1);
    tick();
    Instr_D = 32'h0000_0000;
    push("ds_after_bd", S_BD, 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
Decode stage of the P7 five-stage MIPS pipeline. It consumes the IF/ID register outputs (PC, PC_4, Instr, ErrStat_IF_to_ID, Err_IF_to_ID) and holds the 32x32 general register file. It resolves branches and jumps combinationally, returning the redirect to IF. It latches decoded operands into the ID/EX pipeline register, together with exception status and the branch-delay-slot flag for CP0.

Parameters:
PC_RESET, 32'h0000_3000, PC value loaded into the ID/EX register on reset, flush or bubble.
ERR_NONE, 5'd31, ExcCode meaning "no exception".
ERR_RI, 5'd10, reserved-instruction ExcCode.

Ports:
clk  in  1  clock; all registers update on the rising edge.
reset  in  1  asynchronous, active-high; clears the GRF, ID/EX register and delay-slot tracker.
PC_D  in  32  PC of the instruction in ID.
PC_4_D  in  32  PC+4 of the instruction in ID.
Instr_D  in  32  instruction in ID.
ErrStat_D  in  5  ExcCode from IF (AdEL or 31).
Err_D  in  1  IF exception flag.
Stall  in  1  hazard-unit stall; inserts a bubble into ID/EX.
ErrSignal  in  1  exception taken; flush.
eretEn  in  1  eret taken; flush.
fwd_rs_en  in  1  use fwd_rs_data instead of the GRF for rs.
fwd_rs_data  in  32  forwarded rs value.
fwd_rt_en  in  1  use fwd_rt_data instead of the GRF for rt.
fwd_rt_data  in  32  forwarded rt value.
wb_we  in  1  GRF write enable from WB.
wb_addr  in  5  GRF write address.
wb_data  in  32  GRF write data.
branch  out  1  taken beq/bne (combinational, to IF).
jump  out  1  j/jal/jr/jalr (combinational, to IF).
branch_addr32  out  32  branch target.
jump_addr32  out  32  jump target.
PC_E, PC_4_E, Instr_E  out  32 each  registered to EX.
RS_E, RT_E  out  32 each  registered operand values.
Imm_E  out  32  registered extended immediate.
ErrStat_E  out  5  registered ExcCode.
Err_E  out  1  registered exception flag.
BD_E  out  1  registered branch-delay-slot flag.

Behaviour:
- GRF
  - $0 always reads 0; writes to address 0 are ignored.
  - Writes land on the clk edge when wb_we is high.
  - Read bypass: if wb_we is high, wb_addr equals the read address and the address is nonzero, the read returns wb_data in the same cycle.
  - Operand priority: fwd_*_en, then bypass, then array.
- Decoded set: addu, subu, and, or, slt, sll, jr, jalr, ori, addiu, lui, lw, sw, beq, bne, j, jal, mfc0, mtc0, eret, nop (all-zero).
  - Any other opcode/funct sets ERR_RI.
  - An incoming Err_D=1 takes priority and keeps ErrStat_D.
- Immediate extension
  - ori: zero-extend.
  - lui: imm<<16.
  - Others: sign-extend.
- Branch and jump (combinational)
  - branch_addr32 = PC_4_D + (sext(imm)<<2).
  - branch = beq&(rs==rt) | bne&(rs!=rt), using the forwarded values.
  - j/jal: jump_addr32 = {PC_4_D[31:28], index, 2'b00}.
  - jr/jalr: jump_addr32 = rs value.
  - branch and jump are forced to 0 when Stall, Err_D or RI is asserted.
- Delay-slot tracker
  - Register prev_jb is set when a non-stalled, non-flushed ID instruction is beq/bne/j/jal/jr/jalr, and cleared otherwise.
  - The tracker holds its value on Stall.
  - BD_E is latched from prev_jb.
- ID/EX register update priority:
  1. reset (async): bubble.
  2. ErrSignal | eretEn: bubble and prev_jb := 0.
  3. Stall: bubble; the IF/ID side holds upstream.
  4. Otherwise: load.
- Bubble contents: PC_E=PC_RESET, PC_4_E=PC_RESET+4, Instr_E=0, RS_E=RT_E=Imm_E=0, ErrStat_E=31, Err_E=0, BD_E=0.
- On a load where Err_D or RI is set: Instr_E=0 (nop), Err_E=1, ErrStat_E=ErrStat_D or ERR_RI, with PC_E and BD_E still valid for EPC.
- PC_E = {PC_D[31:2], 2'b00} only when no exception is pending; otherwise PC_D is passed unmodified so BadVAddr is preserved.
- Latency: one cycle from ID to EX outputs; redirect outputs have zero latency.

Test Plan:
- Reset mid-run: assert reset asynchronously between edges → all ID/EX outputs equal the bubble values immediately and GRF $5 reads 0.
- WB bypass: wb_we=1, wb_addr=8, wb_data=32'h1234 while Instr_D=beq $8,$0,+4 and $0=0 → branch=0. Same with bne → branch=1, branch_addr32 = PC_4_D+16.
- Forward priority: fwd_rs_en=1, fwd_rs_data=32'h3010, Instr_D=jr $31 → jump=1, jump_addr32=32'h3010. A write of 7 to $0 then reads 0.
- RI: Instr_D=32'hFC00_0000 at PC 32'h3008 → next edge Instr_E=0, Err_E=1, ErrStat_E=10, PC_E=32'h3008. AdEL input at PC 32'h3001 → ErrStat_E=4, PC_E=32'h3001.
- Stall vs flush: Stall=1 with addu → bubble, prev_jb held. Simultaneous Stall and ErrSignal → bubble, prev_jb=0.
- Delay slot: beq (not taken), then addu at the next edge → BD_E=1 for the addu and 0 for the following instruction.
